// File: rtl/rrat.sv
// rrat: retirement RAT holding the committed arch-to-phys map, freeing displaced tags and counting retires
module rrat #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_BITS = 6,
  parameter int ARCH_BITS = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           commit_valid,
  input  logic                           commit_regwrite,
  input  logic [ARCH_BITS-1:0]           commit_rd,
  input  logic [PHYS_BITS-1:0]           commit_pd,
  output logic                           flist_enqueue,
  output logic [PHYS_BITS-1:0]           flist_phys_reg,
  input  logic                           flush,
  output logic                           restore_valid,
  output logic [ARCH_REGS*PHYS_BITS-1:0] arch_map,
  output logic [63:0]                    instret
);
  localparam logic IDLE = 1'b0;
  localparam logic RESTORE = 1'b1;
  logic [PHYS_BITS-1:0] map_q [ARCH_REGS];
  logic state;
  logic qual;
  assign qual = commit_valid && commit_regwrite && commit_rd != '0;
  assign restore_valid = state == RESTORE;
  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
    assign arch_map[g*PHYS_BITS +: PHYS_BITS] = map_q[g];
  end
  // a flush arriving while in RESTORE extends it by another cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHYS_BITS'(i);
      flist_enqueue <= 1'b0;
      flist_phys_reg <= '0;
      state <= IDLE;
      instret <= '0;
    end else begin
      if (qual) begin
        map_q[commit_rd] <= commit_pd;
        flist_phys_reg <= map_q[commit_rd];
      end
      flist_enqueue <= qual;
      state <= flush ? RESTORE : IDLE;
      instret <= instret + {63'd0, commit_valid};
    end
  end
endmodule

// File: tb/tb_rrat.sv
// tb_rrat: directed stimulus checked every cycle against a behavioural model plus literal spot checks
module tb_rrat;
  logic clk = 0;
  logic rst, commit_valid, commit_regwrite, flush;
  logic [4:0] commit_rd;
  logic [5:0] commit_pd;
  logic flist_enqueue, restore_valid;
  logic [5:0] flist_phys_reg;
  logic [191:0] arch_map;
  logic [63:0] instret;
  int asserts = 0, errs = 0;
  bit chk = 0;
  int m_map [32];
  bit m_en, m_rv;
  int m_reg;
  longint unsigned m_ret;
  logic [191:0] ident;

  rrat dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_regwrite(commit_regwrite),
    .commit_rd(commit_rd), .commit_pd(commit_pd), .flist_enqueue(flist_enqueue),
    .flist_phys_reg(flist_phys_reg), .flush(flush), .restore_valid(restore_valid),
    .arch_map(arch_map), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [191:0] act, logic [191:0] exp);
    asserts++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [191:0] mvec();
    logic [191:0] v;
    for (int i = 0; i < 32; i++) v[i*6 +: 6] = 6'(m_map[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_map[i] = i;
      m_en = 0; m_reg = 0; m_rv = 0; m_ret = 0;
    end else begin
      m_en = commit_valid && commit_regwrite && commit_rd != 0;
      if (m_en) begin
        m_reg = m_map[commit_rd];
        m_map[commit_rd] = commit_pd;
      end
      m_rv = flush;
      if (commit_valid) m_ret = m_ret + 1;
    end
  end

  always @(negedge clk) if (chk) begin
    check("enqueue", 192'(flist_enqueue), 192'(m_en));
    if (m_en) check("phys_reg", 192'(flist_phys_reg), 192'(m_reg));
    check("restore_valid", 192'(restore_valid), 192'(m_rv));
    check("instret", 192'(instret), 192'(m_ret));
    check("arch_map", arch_map, mvec());
  end

  task automatic cyc(bit cv, bit rw, int rd, int pd, bit fl, bit r);
    @(negedge clk);
    commit_valid = cv; commit_regwrite = rw; commit_rd = 5'(rd); commit_pd = 6'(pd);
    flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ident[i*6 +: 6] = 6'(i);
    rst = 0; commit_valid = 0; commit_regwrite = 0; commit_rd = 0; commit_pd = 0; flush = 0;
    @(posedge clk);
    #1 chk = 1;
    cyc(0, 0, 0, 0, 0, 0);
    check("reset map", arch_map, ident);
    check("reset instret", 192'(instret), 192'd0);
    check("reset enqueue", 192'(flist_enqueue), 192'd0);
    check("reset restore", 192'(restore_valid), 192'd0);
    cyc(1, 1, 5, 40, 0, 1);
    check("single enq", 192'(flist_enqueue), 192'd1);
    check("single freed", 192'(flist_phys_reg), 192'd5);
    check("single entry5", 192'(arch_map[30 +: 6]), 192'd40);
    check("single instret", 192'(instret), 192'd1);
    cyc(1, 1, 7, 33, 0, 1);
    check("b2b first freed", 192'(flist_phys_reg), 192'd7);
    cyc(1, 1, 7, 50, 0, 1);
    check("b2b second freed", 192'(flist_phys_reg), 192'd33);
    check("b2b entry7", 192'(arch_map[42 +: 6]), 192'd50);
    cyc(1, 1, 0, 44, 0, 1);
    check("x0 no push", 192'(flist_enqueue), 192'd0);
    check("x0 entry0", 192'(arch_map[0 +: 6]), 192'd0);
    check("x0 instret", 192'(instret), 192'd4);
    cyc(1, 0, 3, 20, 0, 1);
    check("nowrite no push", 192'(flist_enqueue), 192'd0);
    check("nowrite entry3", 192'(arch_map[18 +: 6]), 192'd3);
    cyc(1, 1, 10, 60, 1, 1);
    check("flush restore", 192'(restore_valid), 192'd1);
    check("flush entry10", 192'(arch_map[60 +: 6]), 192'd60);
    check("flush enq", 192'(flist_enqueue), 192'd1);
    check("flush freed", 192'(flist_phys_reg), 192'd10);
    cyc(0, 0, 0, 0, 0, 1);
    check("restore one cycle", 192'(restore_valid), 192'd0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    check("flush in restore", 192'(restore_valid), 192'd1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 9, 21, 1, 1);
    cyc(1, 1, 9, 22, 0, 0);
    check("midreset restore", 192'(restore_valid), 192'd0);
    check("midreset enq", 192'(flist_enqueue), 192'd0);
    check("midreset map", arch_map, ident);
    check("midreset instret", 192'(instret), 192'd0);
    for (int i = 1; i <= 60; i++) cyc(i % 5 != 4, i % 3 != 0, i % 32, (i * 7) % 64, i % 11 == 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
    $finish;
  end
endmodule

// File: doc/rrat.md
# rrat

Retirement register alias table for the out-of-order core. Sits between the ROB commit port and the free list. On each committed register write it records the committed architectural-to-physical mapping, and pushes the displaced physical register into the free list. On a flush it presents the committed map for restoring the speculative RAT. It also keeps the retired-instruction count.

## Interface

Parameters:
- ARCH_REGS, 32: number of architectural registers; entry 0 is x0.
- PHYS_BITS, 6: physical register tag width (64 physical registers).
- ARCH_BITS, 5: architectural index width, equal to clog2(ARCH_REGS).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous and active-low: state resets on a rising clk edge while rst = 0.
- commit_valid  in  1  ROB head instruction retires this cycle.
- commit_regwrite  in  1  retiring instruction writes a destination register.
- commit_rd  in  ARCH_BITS  architectural destination.
- commit_pd  in  PHYS_BITS  physical register allocated to commit_rd at rename.
- flist_enqueue  out  1  push the freed tag into the free list; registered.
- flist_phys_reg  out  PHYS_BITS  freed physical tag; registered.
- flush  in  1  pipeline flush from the ROB.
- restore_valid  out  1  single-cycle pulse: arch_map is the committed map to copy into the speculative RAT.
- arch_map  out  ARCH_REGS*PHYS_BITS  current committed map, continuously driven; entry i occupies bits [i*PHYS_BITS +: PHYS_BITS].
- instret  out  64  count of retired instructions.

## Operation

- **Storage:** the table holds ARCH_REGS entries of PHYS_BITS each.
- **Reset:**
  - entry i = i, so p0–p31 are mapped, which matches the free list's reset contents of p32–p63.
  - flist_enqueue = 0, flist_phys_reg = 0.
  - restore_valid = 0, instret = 0.
  - The state machine goes to IDLE.
- **Commit.** A commit is qualified when commit_valid = 1, commit_regwrite = 1 and commit_rd ≠ 0. For a qualified commit:
  - old = table[commit_rd], read before the update.
  - table[commit_rd] ← commit_pd.
  - Next cycle: flist_enqueue = 1 and flist_phys_reg = old.
- **Non-qualified commits:**
  - commit_valid = 1 with rd = 0 or regwrite = 0 leaves the table unchanged and gives flist_enqueue = 0 next cycle.
  - Entry 0 is never written and stays p0.
- **instret:** increments by 1 on every commit_valid = 1, regardless of regwrite or rd. It wraps modulo 2^64 and is unaffected by flush.
- **No backpressure:** every freed tag was previously mapped, so the free list can never be full on enqueue. The block has no stall.
- **Back-to-back commits to the same rd:** the second commit reads the table after the first has updated it, so it frees the first commit's pd.
- **State machine, states IDLE and RESTORE:**
  - IDLE → RESTORE when flush = 1.
  - RESTORE → IDLE unconditionally after one cycle.
  - restore_valid = 1 exactly while the state is RESTORE.
- **Commit in the flush cycle:** a commit presented in the same cycle as flush is the instruction that caused the flush. It is fully processed, including the table update and the free push. Its mapping is visible in arch_map during the RESTORE cycle.
- **Flush during RESTORE:** the state stays RESTORE for one more cycle, so restore_valid remains high.
- **Commits during RESTORE:** processed normally. The ROB guarantees none occur.
- **Reset mid-operation:** an active rst overrides every other input in that cycle, including a pending free push and RESTORE.

## Timing

- Commit at edge N writes the table at N.
- arch_map reflects the new entry after N.
- flist_enqueue and flist_phys_reg are valid in the cycle after N and drop at N+1 unless another qualified commit occurs.
- flush sampled at edge N gives restore_valid = 1 for the cycle after N. The RAT copies arch_map at edge N+1.
- The free-list push for a flush-cycle commit lands at edge N+1, the same edge the free list restores its head. The free list applies the enqueue together with its head restore.
- arch_map is read-combinational from flops; there are no combinational paths from inputs to outputs.

## Test plan

1. **Reset values:** hold rst = 0 for 2 cycles → arch_map entry i = i for all i, instret = 0, flist_enqueue = 0, restore_valid = 0.
2. **Single commit:** commit rd = 5, pd = 40 → next cycle flist_enqueue = 1 and flist_phys_reg = 5; entry 5 = 40; instret = 1.
3. **Back-to-back same rd:** commit rd = 7, pd = 33, then rd = 7, pd = 50 on consecutive cycles → pushes 7 then 33 on consecutive cycles; entry 7 = 50.
4. **Non-writing commits:**
   - commit rd = 0, pd = 44, regwrite = 1 → entry 0 stays 0, no push, instret increments.
   - regwrite = 0 with rd = 3 → entry 3 unchanged, no push.
5. **Flush with commit:** flush together with a commit of rd = 10, pd = 60 → next cycle restore_valid = 1 for exactly one cycle, entry 10 = 60, flist_phys_reg = 10 with enqueue = 1.
6. **Reset mid-flush:** rst = 0 in the cycle after flush → restore_valid = 0, table back to the identity map, no push.
